// File: rtl/reservation_station.sv
// reservation_station
//   Per-functional-unit reservation station. Holds renamed instructions in an
//   age-ordered compacting queue (entry 0 is oldest), wakes waiting operands
//   from the completion broadcast, and issues the oldest fully-ready entry
//   through a registered valid/ready issue port.
//
// Ports
//   clk_i, reset_i                 clock, synchronous active-high reset
//   writeEn_i                      decode selects this station
//   robTag_i, tag1_i, tag2_i       destination tag and operand tags (0 = value present)
//   val1_i, val2_i, commands_i     operand values (bit 64 ignored) and command word
//   stall_o                        station full
//   cdbValid_i, cdbTag_i, cdbVal_i completion broadcast (only [63:0] captured)
//   issueValid_o, fuReady_i        issue handshake
//   issueTag_o, issueVal1_o,
//   issueVal2_o, issueCommands_o   issued instruction fields
module reservation_station #(
  parameter int ROBsize    = 32,
  parameter int ROBsizeLog = $clog2(ROBsize + 1),
  parameter int DEPTH      = 4,
  parameter int DEPTHLog   = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  writeEn_i,
  input  logic [ROBsizeLog-1:0] robTag_i,
  input  logic [ROBsizeLog-1:0] tag1_i,
  input  logic [ROBsizeLog-1:0] tag2_i,
  input  logic [64:0]           val1_i,
  input  logic [64:0]           val2_i,
  input  logic [9:0]            commands_i,
  output logic                  stall_o,
  input  logic                  cdbValid_i,
  input  logic [ROBsizeLog-1:0] cdbTag_i,
  input  logic [64:0]           cdbVal_i,
  output logic                  issueValid_o,
  input  logic                  fuReady_i,
  output logic [ROBsizeLog-1:0] issueTag_o,
  output logic [63:0]           issueVal1_o,
  output logic [63:0]           issueVal2_o,
  output logic [9:0]            issueCommands_o
);

  typedef struct packed {
    logic [ROBsizeLog-1:0] rob;
    logic [ROBsizeLog-1:0] tag1;
    logic [ROBsizeLog-1:0] tag2;
    logic [63:0]           val1;
    logic [63:0]           val2;
    logic [9:0]            cmd;
  } entry_t;

  entry_t              ent_q [DEPTH];
  entry_t              ent_w [DEPTH];
  entry_t              ent_n [DEPTH];
  entry_t              sel_ent;
  entry_t              new_ent;
  logic [DEPTHLog-1:0] count_q;
  logic [DEPTHLog-1:0] count_n;
  logic [DEPTHLog-1:0] sel;
  logic [DEPTHLog-1:0] wr_idx;
  logic                any_ready;
  logic                do_issue;
  logic                do_write;
  logic                unused_bits;

  // Bit 64 of the value buses carries nothing this station needs.
  assign unused_bits = ^{val1_i[64], val2_i[64], cdbVal_i[64]};

  // Tag 0 means "value present" and therefore never matches a broadcast.
  function automatic logic snoop_hit(input logic [ROBsizeLog-1:0] tag,
                                     input logic                  cdb_valid,
                                     input logic [ROBsizeLog-1:0] cdb_tag);
    return cdb_valid && (tag != '0) && (tag == cdb_tag);
  endfunction

  assign stall_o  = (count_q == DEPTHLog'(DEPTH));
  assign do_write = writeEn_i & ~stall_o;

  always_comb begin
    any_ready = 1'b0;
    sel       = '0;
    sel_ent   = '0;
    // Descending scan so the lowest (oldest) ready index is the one kept.
    // Readiness is taken from registered state only.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (DEPTHLog'(i) < count_q && ent_q[i].tag1 == '0 && ent_q[i].tag2 == '0) begin
        any_ready = 1'b1;
        sel       = DEPTHLog'(i);
        sel_ent   = ent_q[i];
      end
    end
    do_issue = any_ready & (~issueValid_o | fuReady_i);

    // Wakeup of stored entries from the broadcast.
    for (int i = 0; i < DEPTH; i++) begin
      ent_w[i] = ent_q[i];
      if (DEPTHLog'(i) < count_q) begin
        if (snoop_hit(ent_q[i].tag1, cdbValid_i, cdbTag_i)) begin
          ent_w[i].val1 = cdbVal_i[63:0];
          ent_w[i].tag1 = '0;
        end
        if (snoop_hit(ent_q[i].tag2, cdbValid_i, cdbTag_i)) begin
          ent_w[i].val2 = cdbVal_i[63:0];
          ent_w[i].tag2 = '0;
        end
      end
    end

    // Incoming entry, with bypass from a same-cycle broadcast.
    new_ent.rob  = robTag_i;
    new_ent.tag1 = tag1_i;
    new_ent.tag2 = tag2_i;
    new_ent.val1 = val1_i[63:0];
    new_ent.val2 = val2_i[63:0];
    new_ent.cmd  = commands_i;
    if (snoop_hit(tag1_i, cdbValid_i, cdbTag_i)) begin
      new_ent.val1 = cdbVal_i[63:0];
      new_ent.tag1 = '0;
    end
    if (snoop_hit(tag2_i, cdbValid_i, cdbTag_i)) begin
      new_ent.val2 = cdbVal_i[63:0];
      new_ent.tag2 = '0;
    end

    // Compact over the issued slot, then append behind the surviving entries.
    for (int i = 0; i < DEPTH; i++) begin
      ent_n[i] = ent_w[i];
    end
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (do_issue && DEPTHLog'(i) >= sel) begin
        ent_n[i] = ent_w[i+1];
      end
    end
    wr_idx = count_q - DEPTHLog'(do_issue);
    for (int i = 0; i < DEPTH; i++) begin
      if (do_write && DEPTHLog'(i) == wr_idx) begin
        ent_n[i] = new_ent;
      end
    end
    count_n = count_q + DEPTHLog'(do_write) - DEPTHLog'(do_issue);
  end

  // Queue storage: only the occupancy count is reset; slots beyond it are don't-care.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_n;
    end
    for (int i = 0; i < DEPTH; i++) begin
      ent_q[i] <= ent_n[i];
    end
  end

  // Issue register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      issueValid_o    <= 1'b0;
      issueTag_o      <= '0;
      issueVal1_o     <= '0;
      issueVal2_o     <= '0;
      issueCommands_o <= '0;
    end else if (do_issue) begin
      issueValid_o    <= 1'b1;
      issueTag_o      <= sel_ent.rob;
      issueVal1_o     <= sel_ent.val1;
      issueVal2_o     <= sel_ent.val2;
      issueCommands_o <= sel_ent.cmd;
    end else if (fuReady_i) begin
      issueValid_o    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// tb_reservation_station
//   Directed stimulus against reservation_station. A queue-level model tracks
//   the expected outputs and is compared every cycle; literal checks pin
//   the model at the points the scenarios call out.
module tb_reservation_station;
  localparam int DEPTH = 4;
  localparam int TW    = $clog2(32 + 1);

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic          writeEn_i = 1'b0;
  logic [TW-1:0] robTag_i = '0;
  logic [TW-1:0] tag1_i = '0;
  logic [TW-1:0] tag2_i = '0;
  logic [64:0]   val1_i = '0;
  logic [64:0]   val2_i = '0;
  logic [9:0]    commands_i = '0;
  logic          stall_o;
  logic          cdbValid_i = 1'b0;
  logic [TW-1:0] cdbTag_i = '0;
  logic [64:0]   cdbVal_i = '0;
  logic          issueValid_o;
  logic          fuReady_i = 1'b0;
  logic [TW-1:0] issueTag_o;
  logic [63:0]   issueVal1_o;
  logic [63:0]   issueVal2_o;
  logic [9:0]    issueCommands_o;

  int total = 0;
  int bad   = 0;

  reservation_station dut (
    .clk_i          (clk),
    .reset_i        (reset_i),
    .writeEn_i      (writeEn_i),
    .robTag_i       (robTag_i),
    .tag1_i         (tag1_i),
    .tag2_i         (tag2_i),
    .val1_i         (val1_i),
    .val2_i         (val2_i),
    .commands_i     (commands_i),
    .stall_o        (stall_o),
    .cdbValid_i     (cdbValid_i),
    .cdbTag_i       (cdbTag_i),
    .cdbVal_i       (cdbVal_i),
    .issueValid_o   (issueValid_o),
    .fuReady_i      (fuReady_i),
    .issueTag_o     (issueTag_o),
    .issueVal1_o    (issueVal1_o),
    .issueVal2_o    (issueVal2_o),
    .issueCommands_o(issueCommands_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int              rob;
    int              t1;
    int              t2;
    longint unsigned v1;
    longint unsigned v2;
    int              cmd;
  } ment_t;

  ment_t           mq[$];
  bit              armed = 1'b0;
  bit              e_valid = 1'b0;
  bit              e_stall = 1'b0;
  int              e_tag = 0;
  longint unsigned e_v1 = 0;
  longint unsigned e_v2 = 0;
  int              e_cmd = 0;

  always @(posedge clk) begin : model
    int    idx;
    bit    full;
    ment_t ne;
    if (reset_i) begin
      mq.delete();
      e_valid = 1'b0;
      e_tag   = 0;
      e_v1    = 0;
      e_v2    = 0;
      e_cmd   = 0;
      armed   = 1'b1;
    end else if (armed) begin
      full = (mq.size() == DEPTH);
      idx  = -1;
      for (int i = 0; i < mq.size(); i++)
        if (idx < 0 && mq[i].t1 == 0 && mq[i].t2 == 0) idx = i;
      if (idx >= 0 && (!e_valid || fuReady_i)) begin
        e_valid = 1'b1;
        e_tag   = mq[idx].rob;
        e_v1    = mq[idx].v1;
        e_v2    = mq[idx].v2;
        e_cmd   = mq[idx].cmd;
        mq.delete(idx);
      end else if (e_valid && fuReady_i) begin
        e_valid = 1'b0;
      end
      if (cdbValid_i && cdbTag_i != 0) begin
        for (int i = 0; i < mq.size(); i++) begin
          if (mq[i].t1 == int'(cdbTag_i)) begin mq[i].t1 = 0; mq[i].v1 = cdbVal_i[63:0]; end
          if (mq[i].t2 == int'(cdbTag_i)) begin mq[i].t2 = 0; mq[i].v2 = cdbVal_i[63:0]; end
        end
      end
      if (writeEn_i && !full) begin
        ne.rob = int'(robTag_i);
        ne.t1  = int'(tag1_i);
        ne.t2  = int'(tag2_i);
        ne.v1  = val1_i[63:0];
        ne.v2  = val2_i[63:0];
        ne.cmd = int'(commands_i);
        if (cdbValid_i && ne.t1 != 0 && ne.t1 == int'(cdbTag_i)) begin ne.t1 = 0; ne.v1 = cdbVal_i[63:0]; end
        if (cdbValid_i && ne.t2 != 0 && ne.t2 == int'(cdbTag_i)) begin ne.t2 = 0; ne.v2 = cdbVal_i[63:0]; end
        mq.push_back(ne);
      end
    end
    e_stall = (mq.size() == DEPTH);
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("m_stall", 64'(stall_o), 64'(e_stall));
      chk("m_valid", 64'(issueValid_o), 64'(e_valid));
      chk("m_tag", 64'(issueTag_o), 64'(e_tag));
      chk("m_val1", issueVal1_o, e_v1);
      chk("m_val2", issueVal2_o, e_v2);
      chk("m_cmd", 64'(issueCommands_o), 64'(e_cmd));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    writeEn_i  = 1'b0;
    cdbValid_i = 1'b0;
  endtask

  task automatic wr(input int rob, input int t1, input int t2,
                    input logic [63:0] v1, input logic [63:0] v2, input int cmd);
    logic [31:0] r, a, b, c;
    r = rob; a = t1; b = t2; c = cmd;
    writeEn_i  = 1'b1;
    robTag_i   = r[TW-1:0];
    tag1_i     = a[TW-1:0];
    tag2_i     = b[TW-1:0];
    val1_i     = {1'b1, v1};
    val2_i     = {1'b1, v2};
    commands_i = c[9:0];
  endtask

  task automatic cdb(input int tag, input logic [63:0] v);
    logic [31:0] t;
    t = tag;
    cdbValid_i = 1'b1;
    cdbTag_i   = t[TW-1:0];
    cdbVal_i   = {1'b1, v};
  endtask

  task automatic expect_issue(input string nm, input int tag);
    chk({nm, "_valid"}, 64'(issueValid_o), 64'd1);
    chk({nm, "_tag"}, 64'(issueTag_o), 64'(tag));
  endtask

  initial begin
    tick();
    tick();
    reset_i = 1'b0;
    chk("rst_valid", 64'(issueValid_o), 64'd0);
    chk("rst_stall", 64'(stall_o), 64'd0);
    chk("rst_tag", 64'(issueTag_o), 64'd0);

    // Minimum-latency issue of a ready entry
    fuReady_i = 1'b1;
    wr(5, 0, 0, 64'd10, 64'd20, 'h021);
    tick();
    chk("t1_early", 64'(issueValid_o), 64'd0);
    tick();
    expect_issue("t1", 5);
    chk("t1_val1", issueVal1_o, 64'd10);
    chk("t1_val2", issueVal2_o, 64'd20);
    chk("t1_cmd", 64'(issueCommands_o), 64'h021);
    tick();
    chk("t1_drop", 64'(issueValid_o), 64'd0);
    chk("t1_hold", 64'(issueTag_o), 64'd5);

    // Wakeup from broadcast; non-matching broadcast ignored
    wr(7, 3, 0, 64'h99, 64'd1, 2);
    tick();
    cdb(4, 64'h77);
    tick();
    chk("t2_nomatch", 64'(issueValid_o), 64'd0);
    cdb(3, 64'h55);
    tick();
    chk("t2_wake_edge", 64'(issueValid_o), 64'd0);
    tick();
    expect_issue("t2", 7);
    chk("t2_val1", issueVal1_o, 64'h55);
    tick();

    // Write-time bypass
    wr(8, 0, 9, 64'd1, 64'd0, 3);
    cdb(9, 64'hAA);
    tick();
    tick();
    expect_issue("t3", 8);
    chk("t3_val2", issueVal2_o, 64'hAA);
    tick();

    // Fill to full with the issue register held
    fuReady_i = 1'b0;
    wr(6, 0, 0, 64'd6, 64'd6, 1);  tick();
    wr(1, 0, 0, 64'd1, 64'd1, 1);  tick();
    wr(2, 0, 0, 64'd2, 64'd2, 1);  tick();
    wr(3, 0, 0, 64'd3, 64'd3, 1);  tick();
    chk("t4_not_full", 64'(stall_o), 64'd0);
    wr(4, 0, 0, 64'd4, 64'd4, 1);  tick();
    chk("t4_full", 64'(stall_o), 64'd1);
    expect_issue("t4_held", 6);
    wr(13, 0, 0, 64'd13, 64'd13, 1); tick();
    chk("t4_still_full", 64'(stall_o), 64'd1);
    chk("t4_still_held", 64'(issueTag_o), 64'd6);
    fuReady_i = 1'b1;
    tick(); expect_issue("t4_a", 1);
    chk("t4_unstall", 64'(stall_o), 64'd0);
    tick(); expect_issue("t4_b", 2);
    tick(); expect_issue("t4_c", 3);
    tick(); expect_issue("t4_d", 4);
    tick();
    chk("t4_dropped", 64'(issueValid_o), 64'd0);

    // Younger ready entry bypasses an older waiting one
    wr(11, 2, 0, 64'd0, 64'd5, 4);  tick();
    wr(12, 0, 0, 64'd7, 64'd8, 5);  tick();
    chk("t5_none", 64'(issueValid_o), 64'd0);
    tick();
    expect_issue("t5_b", 12);
    cdb(2, 64'h2222);
    tick();
    chk("t5_gap", 64'(issueValid_o), 64'd0);
    tick();
    expect_issue("t5_a", 11);
    chk("t5_val1", issueVal1_o, 64'h2222);
    chk("t5_val2", issueVal2_o, 64'd5);
    tick();

    // Write + issue + wakeup on one edge
    wr(30, 5, 0, 64'd0, 64'd1, 7);  tick();
    wr(31, 0, 0, 64'd2, 64'd3, 8);  tick();
    wr(32, 0, 5, 64'd9, 64'd0, 6);
    cdb(5, 64'h5555);
    tick();
    expect_issue("t7_b", 31);
    tick();
    expect_issue("t7_a", 30);
    chk("t7_a_val1", issueVal1_o, 64'h5555);
    tick();
    expect_issue("t7_c", 32);
    chk("t7_c_val2", issueVal2_o, 64'h5555);
    tick();

    // Reset mid-operation
    fuReady_i = 1'b0;
    wr(21, 0, 0, 64'd1, 64'd1, 1);  tick();
    wr(22, 0, 0, 64'd2, 64'd2, 1);  tick();
    wr(23, 0, 0, 64'd3, 64'd3, 1);  tick();
    wr(24, 0, 0, 64'd4, 64'd4, 1);  tick();
    expect_issue("t6_pre", 21);
    reset_i = 1'b1;
    wr(25, 0, 0, 64'd5, 64'd5, 1);
    tick();
    reset_i   = 1'b0;
    fuReady_i = 1'b1;
    chk("t6_valid", 64'(issueValid_o), 64'd0);
    chk("t6_stall", 64'(stall_o), 64'd0);
    chk("t6_tag", 64'(issueTag_o), 64'd0);
    tick();
    tick();
    tick();
    chk("t6_quiet", 64'(issueValid_o), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reservation_station.md
Name: reservation_station

Overview:
- Per-functional-unit reservation station directly downstream of decode. One instance per whichMath class (four total).
- Accepts renamed instructions carrying a destination ROB tag, two operand tag/value pairs and a 10-bit command word.
- Snoops the completion broadcast to wake up waiting operands.
- Issues the oldest fully-ready entry to its functional unit through a registered valid/ready output.

Parameters:
- ROBsize, 32, number of ROB entries.
- ROBsizeLog, $clog2(ROBsize+1), tag width; tag value 0 means "operand already present".
- DEPTH, 4, number of RS entries.
- DEPTHLog, $clog2(DEPTH+1), occupancy counter width.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- writeEn_i  in  1  decode selects this RS (RSWriteEn_o[g])
- robTag_i  in  ROBsizeLog  destination ROB tag (next tail)
- tag1_i  in  ROBsizeLog  operand 1 tag, 0 = value valid
- tag2_i  in  ROBsizeLog  operand 2 tag, 0 = value valid
- val1_i  in  65  operand 1 value; bit 64 ignored on input
- val2_i  in  65  operand 2 value; bit 64 ignored on input
- commands_i  in  10  command word (memWrite, memToReg, ALUOp, regWrite, needToForward, leftShift, saveCond, read_enable)
- stall_o  out  1  RS full
- cdbValid_i  in  1  completion broadcast valid (robWriteEn)
- cdbTag_i  in  ROBsizeLog  completing ROB tag
- cdbVal_i  in  65  completing value; only [63:0] captured
- issueValid_o  out  1  issue register holds an instruction
- fuReady_i  in  1  functional unit accepts the instruction this cycle
- issueTag_o  out  ROBsizeLog  destination ROB tag of the issued entry
- issueVal1_o  out  64  operand 1
- issueVal2_o  out  64  operand 2
- issueCommands_o  out  10  command word

Behaviour:
- Reset (synchronous, any cycle, including mid-operation): all entries invalid, occupancy 0, issueValid_o=0, issueTag_o/issueVal1_o/issueVal2_o/issueCommands_o=0, stall_o=0. Pending writes and broadcasts in the reset cycle are discarded.
- Storage: age-ordered compacting queue. Entry 0 is oldest; valid entries are always contiguous from index 0.
- stall_o = (occupancy == DEPTH), combinational from the registered count. It is not relieved by a same-cycle issue, which keeps it conservative and consistent with decode's stall & writeEn gating.
- Write: accepted on an edge when writeEn_i & ~stall_o. The entry is appended at index occupancy−(issue this cycle ? 1 : 0).
- Write-time bypass: if cdbValid_i and tagN_i != 0 and tagN_i == cdbTag_i, store cdbVal_i[63:0] as operand N with tag 0.
- Wakeup: on every edge, each valid stored entry whose operand tag is nonzero and equals cdbTag_i (with cdbValid_i=1) captures cdbVal_i[63:0] and clears that tag. Both operands may wake on the same broadcast. cdbTag_i==0 never matches.
- Ready: an entry is ready when both stored tags are 0. Readiness uses registered state only, so wakeup takes effect for selection on the following cycle.
- Issue register load: occurs when (~issueValid_o | fuReady_i) and at least one ready entry exists.
  - Selection picks the lowest-index (oldest) ready entry.
  - That entry is removed and younger entries shift down by one.
  - issueValid_o=1 next cycle with the entry's fields.
- Issue register clear: if (issueValid_o & fuReady_i) and no ready entry exists, issueValid_o←0. Output fields hold their last values.
- Holding: while issueValid_o & ~fuReady_i, all issue outputs stay stable.
- Minimum latency: a write at edge t with both tags 0 reaches issueValid_o=1 after edge t+1.
- Simultaneous write + issue + wakeup on one edge:
  - Occupancy changes by (+1 write, −1 issue).
  - Shift and append are applied consistently; no entry is lost or duplicated.
- Occupancy counter never exceeds DEPTH and never underflows.

Test Plan:
- Reset, then write robTag=5, tag1=0, tag2=0, val1=10, val2=20, commands=0x021, fuReady=1 → issueValid_o=1 after the second edge with issueTag_o=5, issueVal1_o=10, issueVal2_o=20, issueCommands_o=0x021; issueValid_o=0 the following cycle.
- Write robTag=7, tag1=3; two cycles later cdbValid=1, cdbTag=3, cdbVal=0x55 → entry issues the cycle after wakeup with issueVal1_o=0x55; broadcasts with cdbTag=4 cause no change.
- Write tag2=9 in the same cycle as cdbValid=1, cdbTag=9, cdbVal=0xAA → entry issues next cycle with issueVal2_o=0xAA (write-time bypass).
- fuReady=0, write 4 ready entries with tags 1..4 → stall_o=1 once occupancy reaches 4; a fifth write is dropped; raising fuReady issues tags 1,2,3,4 in order on consecutive cycles.
- Entry A (tag 11, waiting on tag 2) is older than entry B (tag 12, ready) → B issues first; after broadcast of tag 2, A issues next.
- Assert reset_i with 3 entries queued and issueValid_o=1 → next cycle issueValid_o=0, stall_o=0, and no entry is issued afterwards.
